// File: rtl/fb_fetch_pkg.sv
// -----------------------------------------------------------------------------
// fb_fetch_pkg
// Shared types and helpers for the framebuffer fetch master.
//   fetch_state_e  : bus-master FSM state (IDLE, REQ, WAIT_ACK)
//   FRAME_WORDS    : words per frame for the default 800x480 geometry
//   BYTES_PER_WORD : bytes per bus word for the default 32-bit data path
//   word_addr()    : byte address of framebuffer word 'idx'
// -----------------------------------------------------------------------------
package fb_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_ACK = 2'd2
   } fetch_state_e;

   // Default-geometry values; the fetch master derives its own from parameters.
   localparam int unsigned FRAME_WORDS    = 800 * 480;
   localparam int unsigned BYTES_PER_WORD = 32 / 8;

   // Linear framebuffer address. Computed wide; the caller truncates to the
   // bus address width, which gives plain modulo-2^ADDR_WIDTH arithmetic.
   function automatic logic [63:0] word_addr(input logic [63:0] base,
                                             input logic [63:0] idx,
                                             input logic [63:0] bytes_per_word);
      return base + idx * bytes_per_word;
   endfunction

endpackage

// File: rtl/fb_fetch_master.sv
// -----------------------------------------------------------------------------
// fb_fetch_master
// Wishbone B4 pipelined read master that streams the framebuffer linearly,
// in fixed BURST-word bursts, into the write side of the pixel FIFO. A burst
// is only started while the FIFO reports less than half full, so a whole
// burst always fits.
//
// Optional feature (macro FB_FETCH_ERR_EN): adds wb_err_i and a sticky
// bus_error flag. An error beat completes the beat and pushes a zero word so
// pixel alignment is kept.
//
// Ports
//   clk, reset       : clock, asynchronous active-high reset
//   enable           : fetch enable (level); low in IDLE rewinds to pixel 0
//   wb_cyc_o/stb_o   : bus cycle / request strobe
//   wb_we_o, wb_sel_o: tied read, all byte lanes
//   wb_adr_o         : byte address of the current request
//   wb_stall_i       : slave stall (holds request)
//   wb_ack_i, wb_dat_i: read acknowledge and data
//   wb_err_i         : bus error (FB_FETCH_ERR_EN only)
//   bus_error        : sticky error flag (FB_FETCH_ERR_EN only)
//   fifo_write/wdata : FIFO push, combinational from the ack
//   fifo_half_full   : FIFO occupancy >= FIFO_DEPTH/2
//   frame_start      : pulses with the push of pixel 0 of a frame
// -----------------------------------------------------------------------------
module fb_fetch_master #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int unsigned           HDISP      = 800,
   parameter int unsigned           VDISP      = 480,
   parameter int unsigned           BURST      = 16,
   parameter int unsigned           FIFO_DEPTH = 256
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   output logic                      wb_cyc_o,
   output logic                      wb_stb_o,
   output logic                      wb_we_o,
   output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
   output logic [ADDR_WIDTH-1:0]     wb_adr_o,
   input  logic                      wb_stall_i,
   input  logic                      wb_ack_i,
   input  logic [DATA_WIDTH-1:0]     wb_dat_i,
`ifdef FB_FETCH_ERR_EN
   input  logic                      wb_err_i,
   output logic                      bus_error,
`endif
   output logic                      fifo_write,
   output logic [DATA_WIDTH-1:0]     fifo_wdata,
   input  logic                      fifo_half_full,
   output logic                      frame_start
);

   import fb_fetch_pkg::*;

   localparam int unsigned FRAME_LEN  = HDISP * VDISP;
   localparam int unsigned WORD_BYTES = DATA_WIDTH / 8;
   localparam int unsigned PIX_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned CNT_W      = $clog2(BURST + 1);

   localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

   // Elaboration-time configuration checks.
   if (BURST == 0 || BURST > FIFO_DEPTH / 2) begin : g_bad_burst
      $error("fb_fetch_master: BURST must be in 1..FIFO_DEPTH/2");
   end
   if (BURST != 0 && (FRAME_LEN % BURST) != 0) begin : g_bad_frame
      $error("fb_fetch_master: HDISP*VDISP must be a multiple of BURST");
   end
   if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("fb_fetch_master: DATA_WIDTH must be a whole number of bytes");
   end

   fetch_state_e     state_q,   state_d;
   logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;   // index of the next word to request
   logic [CNT_W-1:0] req_cnt_q, req_cnt_d;   // requests accepted in this burst
   logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;   // beats completed in this burst
   logic             sof_q,     sof_d;       // this burst starts at pixel 0
`ifdef FB_FETCH_ERR_EN
   logic             bus_err_q, bus_err_d;
`endif

   logic bus_active;   // cyc is high in every state except IDLE
   logic accept;       // request taken by the slave this cycle
   logic beat;         // a read beat completes this cycle

   assign bus_active = (state_q != IDLE);
   assign accept     = (state_q == REQ) & ~wb_stall_i;
`ifdef FB_FETCH_ERR_EN
   assign beat       = bus_active & (wb_ack_i | wb_err_i);
`else
   assign beat       = bus_active & wb_ack_i;
`endif

   // ---------------------------------------------------------------- registers
   // NOTE: every register gets a reset value on the asynchronous reset edge,
   // so cyc/stb fall in the same cycle reset rises and stale acks see cyc=0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         pix_cnt_q <= '0;
         req_cnt_q <= '0;
         ack_cnt_q <= '0;
         sof_q     <= 1'b0;
`ifdef FB_FETCH_ERR_EN
         bus_err_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of every other register.
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         req_cnt_q <= req_cnt_d;
         ack_cnt_q <= ack_cnt_d;
         sof_q     <= sof_d;
`ifdef FB_FETCH_ERR_EN
         bus_err_q <= bus_err_d;
`endif
      end
   end

   // ------------------------------------------------------- next-state logic
   always_comb begin
      // NOTE: hold-value defaults first, so no path through the case leaves a
      // variable unassigned and infers a latch.
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      req_cnt_d = req_cnt_q;
      ack_cnt_d = ack_cnt_q;
      sof_d     = sof_q;

      unique case (state_q)
         IDLE: begin
            if (!enable) begin
               pix_cnt_d = '0;
            end else if (!fifo_half_full) begin
               state_d   = REQ;
               req_cnt_d = '0;
               ack_cnt_d = '0;
               // Frames end on burst boundaries, so a burst either starts a
               // frame or contains no pixel 0 at all.
               sof_d     = (pix_cnt_q == '0);
            end
         end

         REQ: begin
            if (beat) begin
               ack_cnt_d = ack_cnt_q + 1'b1;
            end
            if (accept) begin
               req_cnt_d = req_cnt_q + 1'b1;
               pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + 1'b1;
               if (req_cnt_q == BURST_LAST) begin
                  // A zero-latency slave may have returned every beat already.
                  state_d = (ack_cnt_d == BURST_CNT) ? IDLE : WAIT_ACK;
               end
            end
         end

         WAIT_ACK: begin
            if (beat) begin
               ack_cnt_d = ack_cnt_q + 1'b1;
            end
            if (ack_cnt_d == BURST_CNT) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

`ifdef FB_FETCH_ERR_EN
   assign bus_err_d = bus_err_q | (bus_active & wb_err_i);
`endif

   // ------------------------------------------------------------ output logic
   always_comb begin
      wb_cyc_o    = bus_active;
      wb_stb_o    = (state_q == REQ);
      wb_we_o     = 1'b0;
      wb_sel_o    = '1;
      wb_adr_o    = ADDR_WIDTH'(word_addr(64'(BASE_ADDR), 64'(pix_cnt_q),
                                          64'(WORD_BYTES)));
      fifo_write  = beat;
`ifdef FB_FETCH_ERR_EN
      fifo_wdata  = wb_err_i ? '0 : wb_dat_i;
      bus_error   = bus_err_q;
`else
      fifo_wdata  = wb_dat_i;
`endif
      // Acks return in request order, so the first beat of a frame-start
      // burst carries pixel 0.
      frame_start = beat & sof_q & (ack_cnt_q == '0);
   end

endmodule

// File: tb/tb_fb_fetch_master.sv
`timescale 1ns/1ps
module tb_fb_fetch_master;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned HD    = 8;
   localparam int unsigned VD    = 8;
   localparam int unsigned BL    = 16;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned FRAME = HD * VD;
   localparam logic [31:0] BASE  = 32'h1000_0040;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]    wb_sel_o;
   logic [AW-1:0] wb_adr_o;
   logic          wb_stall_i, wb_ack_i;
   logic [DW-1:0] wb_dat_i;
   logic          fifo_write;
   logic [DW-1:0] fifo_wdata;
   logic          fifo_half_full;
   logic          frame_start;
`ifdef FB_FETCH_ERR_EN
   logic          wb_err_i;
   logic          bus_error;
`endif

   always #5 clk = ~clk;

   fb_fetch_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
      .HDISP(HD), .VDISP(VD), .BURST(BL), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o),
      .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
`ifdef FB_FETCH_ERR_EN
      .wb_err_i(wb_err_i), .bus_error(bus_error),
`endif
      .fifo_write(fifo_write), .fifo_wdata(fifo_wdata),
      .fifo_half_full(fifo_half_full), .frame_start(frame_start)
   );

   // Outstanding request at the slave, and expected FIFO push.
   typedef struct {
      int unsigned pix;
      logic [31:0] data;
      int unsigned ready;
   } req_t;
   typedef struct {
      logic [31:0] data;
      logic        sof;
   } push_t;

   req_t  pend[$];
   push_t exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Stimulus knobs and reference-model state.
   int unsigned stall_pct  = 0;
   int unsigned max_delay  = 0;
   bit          force_hf   = 1'b0;
   bit          err_mode   = 1'b0;
   bit          err_done   = 1'b0;
   int unsigned cyc_n      = 0;
   int unsigned occ        = 0;   // model FIFO occupancy
   int unsigned last_ready = 0;
   int unsigned exp_pix    = 0;   // next framebuffer word the master should ask for
   int unsigned burst_acc  = 0;
   int unsigned beat_idx   = 0;

   // ------------------------------------------------------------------ slave
   // Drives slave/FIFO inputs at the falling edge, records accepted requests
   // against the linear-fetch model, and queues the expected FIFO pushes.
   initial begin : slave
      req_t  r;
      push_t p;
      bit    is_err;
      wb_stall_i     = 1'b0;
      wb_ack_i       = 1'b0;
      wb_dat_i       = '0;
      fifo_half_full = 1'b0;
`ifdef FB_FETCH_ERR_EN
      wb_err_i       = 1'b0;
`endif
      forever begin
         @(negedge clk);
         cyc_n++;
         if (!wb_cyc_o) begin
            burst_acc = 0;
            beat_idx  = 0;
         end
         if (reset || (!wb_cyc_o && !enable)) exp_pix = 0;
         if ((cyc_n % 4) == 0 && occ > 0) occ--;

         wb_stall_i = (stall_pct != 0) && ($urandom_range(99) < stall_pct);
         wb_ack_i   = 1'b0;
         wb_dat_i   = $urandom;
         is_err     = 1'b0;
`ifdef FB_FETCH_ERR_EN
         wb_err_i   = 1'b0;
`endif
         if (pend.size() != 0 && pend[0].ready <= cyc_n) begin
            r = pend.pop_front();
`ifdef FB_FETCH_ERR_EN
            is_err = err_mode && !err_done && wb_cyc_o && (beat_idx == 2);
`endif
            if (is_err) begin
`ifdef FB_FETCH_ERR_EN
               wb_err_i = 1'b1;
`endif
               err_done = 1'b1;
            end else begin
               wb_ack_i = 1'b1;
               wb_dat_i = r.data;
            end
            if (wb_cyc_o) begin
               p.data = is_err ? 32'h0 : r.data;
               p.sof  = (r.pix == 0);
               exp_q.push_back(p);
               occ++;
               beat_idx++;
               check("fifo_occupancy_le_depth", occ <= DEPTH, 1);
            end
         end

         if (wb_stb_o && !wb_stall_i) begin
            check("accept_addr", wb_adr_o, BASE + exp_pix * 4);
            burst_acc++;
            r.ready = cyc_n + 1 + $urandom_range(max_delay);
            if (r.ready <= last_ready) r.ready = last_ready + 1;
            last_ready = r.ready;
            r.pix      = exp_pix;
            r.data     = $urandom;
            pend.push_back(r);
            exp_pix = (exp_pix + 1) % FRAME;
         end

         fifo_half_full = force_hf || (occ >= DEPTH / 2);
      end
   end

   // ---------------------------------------------------------------- monitor
   int unsigned mon_acc    = 0;
   int unsigned mon_ack    = 0;
   int unsigned total_push = 0;
   int unsigned sof_seen   = 0;
   bit have_prev = 1'b0, prev_reset = 1'b0, prev_cyc = 1'b0, prev_en = 1'b0, prev_hf = 1'b0;
`ifdef FB_FETCH_ERR_EN
   bit bus_err_exp = 1'b0;
`endif

   initial begin : monitor
      push_t p;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            check("reset_cyc", wb_cyc_o, 0);
            check("reset_stb", wb_stb_o, 0);
            check("reset_adr", wb_adr_o, BASE);
            check("reset_fifo_write", fifo_write, 0);
            check("reset_frame_start", frame_start, 0);
            mon_acc = 0;
            mon_ack = 0;
            exp_q.delete();
         end else begin
            if (have_prev && !prev_reset) begin
               if (!prev_cyc) check("burst_start_rule", wb_cyc_o, prev_en && !prev_hf);
               else           check("cyc_until_last_ack", wb_cyc_o, mon_ack < BL);
            end
            if (!wb_cyc_o) begin
               if (prev_cyc && !prev_reset) begin
                  check("burst_accepts", mon_acc, BL);
                  check("burst_pushes", mon_ack, BL);
               end
               check("idle_stb", wb_stb_o, 0);
               mon_acc = 0;
               mon_ack = 0;
            end else begin
               check("stb_until_burst_done", wb_stb_o, mon_acc < BL);
               if (wb_stb_o && !wb_stall_i) mon_acc++;
            end
            if (fifo_write) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_push", 1, 0);
               end else begin
                  p = exp_q.pop_front();
                  check("push_data", fifo_wdata, p.data);
                  check("frame_start", frame_start, p.sof);
               end
               mon_ack++;
               total_push++;
               if (frame_start) sof_seen++;
            end else begin
               check("frame_start_no_push", frame_start, 0);
               if (exp_q.size() != 0) begin
                  check("missing_push", 0, 1);
                  void'(exp_q.pop_front());
               end
            end
         end
`ifdef FB_FETCH_ERR_EN
         if (reset) bus_err_exp = 1'b0;
         check("bus_error", bus_error, bus_err_exp);
         if (!reset && wb_err_i && wb_cyc_o) bus_err_exp = 1'b1;
`endif
         have_prev  = 1'b1;
         prev_reset = reset;
         prev_cyc   = wb_cyc_o;
         prev_en    = enable;
         prev_hf    = fifo_half_full;
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input logic want, input int unsigned budget, input string name);
      int unsigned n = 0;
      while (wb_cyc_o !== want && n < budget) begin
         tick(1);
         n++;
      end
      check(name, wb_cyc_o, want);
   endtask

   initial begin : stimulus
      int unsigned n;
      reset  = 1'b1;
      enable = 1'b0;
      tick(3);
      check("reset_we", wb_we_o, 0);
      check("reset_sel", wb_sel_o, 4'hF);
      reset = 1'b0;

      // Zero-wait slave, ack one cycle after accept; several bursts and wraps.
      enable    = 1'b1;
      stall_pct = 0;
      max_delay = 0;
      tick(200);

      // Throttle: half_full held high blocks new bursts.
      force_hf = 1'b1;
      tick(100);
      check("throttle_no_cyc", wb_cyc_o, 0);
      force_hf = 1'b0;
      wait_cyc(1'b1, 3, "throttle_release_start");

      // Random stall and ack latency.
      stall_pct = 50;
      max_delay = 5;
      tick(1500);

      // Drop enable after 5 accepts of a fresh burst.
      wait_cyc(1'b0, 200, "enable_drop_idle");
      n = 0;
      while (!(wb_cyc_o && burst_acc >= 5) && n < 300) begin
         tick(1);
         n++;
      end
      check("enable_drop_fifth_accept", wb_cyc_o && burst_acc >= 5, 1);
      enable = 1'b0;
      wait_cyc(1'b0, 300, "enable_drop_burst_done");
      tick(3);
      enable = 1'b1;
      wait_cyc(1'b1, 200, "restart_burst");
      check("restart_addr", wb_adr_o, BASE);
      tick(300);

      // Asynchronous reset while requesting.
      n = 0;
      while (wb_stb_o !== 1'b1 && n < 300) begin
         tick(1);
         n++;
      end
      check("reset_wait_req", wb_stb_o, 1);
      reset = 1'b1;
      #1;
      check("async_reset_cyc", wb_cyc_o, 0);
      check("async_reset_stb", wb_stb_o, 0);
      tick(30);
      reset = 1'b0;
      wait_cyc(1'b1, 200, "post_reset_burst");
      check("post_reset_addr", wb_adr_o, BASE);
      tick(200);

`ifdef FB_FETCH_ERR_EN
      // Error on the third beat of one burst.
      err_mode = 1'b1;
      n = 0;
      while (!err_done && n < 500) begin
         tick(1);
         n++;
      end
      check("err_injected", err_done, 1);
      tick(300);
      check("bus_error_sticky", bus_error, 1);
`endif

      enable = 1'b0;
      wait_cyc(1'b0, 300, "final_idle");
      tick(10);
      check("pushes_seen", total_push >= 400, 1);
      check("frame_starts_seen", sof_seen >= 5, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
